// File: rtl/alu_pkg.sv
// Shared opcode and state types for the digit-serial ALU.
// Opcode 111 is signed set-less-than when ALU_SLT_EN is defined; otherwise it is reserved.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_RSV1   = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110,
    OP_SLT    = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// SLICE-bit combinational ALU slice with ripple carry; b is inverted internally for subtraction.
// With ALU_SLT_EN defined, opcode 111 runs as a subtract so the top can derive less-than.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       ctrl,
  output logic [SLICE-1:0] out,
  output logic             cout,
  output logic             c_msb_in
);

  logic             sub_mode;
  logic [SLICE-1:0] b_eff;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   carry;

  always_comb begin
    sub_mode = (ctrl == OP_SUB);
`ifdef ALU_SLT_EN
    if (ctrl == OP_SLT) sub_mode = 1'b1;
`endif
    b_eff    = sub_mode ? ~b : b;
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
    cout     = carry[SLICE];
    c_msb_in = carry[SLICE-1];
  end

  always_comb begin
    out = '0;
    case (ctrl)
      OP_PASS_B: out = b;
      OP_ADD,
      OP_SUB:    out = sum;
      OP_AND:    out = a & b;
      OP_OR:     out = a | b;
      OP_XOR:    out = a ^ b;
`ifdef ALU_SLT_EN
      OP_SLT:    out = sum;
`endif
      default:   out = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit operation processed SLICE bits per cycle with a registered carry.
// Define ALU_SLT_EN to enable opcode 111 as signed set-less-than.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_out;
  logic             sl_cout, sl_cmsb;
  logic             is_arith, is_slt;

  assign sl_a = a_q[cnt_q*SLICE +: SLICE];
  assign sl_b = b_q[cnt_q*SLICE +: SLICE];

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (carry_q),
    .ctrl     (ctrl_q),
    .out      (sl_out),
    .cout     (sl_cout),
    .c_msb_in (sl_cmsb)
  );

  always_comb begin
    is_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
    is_slt   = 1'b0;
`ifdef ALU_SLT_EN
    is_slt   = (ctrl_q == OP_SLT);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    carry_d     = carry_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          ctrl_d     = ctrl;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
          case (ctrl)
            OP_ADD:  carry_d = cin;
            OP_SUB:  carry_d = 1'b1;
`ifdef ALU_SLT_EN
            OP_SLT:  carry_d = 1'b1;
`endif
            default: carry_d = 1'b0;
          endcase
        end
      end
      RUN: begin
        result_d[cnt_q*SLICE +: SLICE] = sl_out;
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // less-than is N xor V of the completed subtraction
          if (is_slt)
            result_d = {{(WIDTH-1){1'b0}}, result_d[WIDTH-1] ^ sl_cmsb ^ sl_cout};
          n_d         = result_d[WIDTH-1];
          z_d         = (result_d == '0);
          c_d         = is_arith & sl_cout;
          v_d         = is_arith & (sl_cmsb ^ sl_cout);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_n    = n_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial at WIDTH=16, SLICE=4: arithmetic reference model, per-cycle output compare,
// directed literal cases, output back-pressure, mid-operation reset and randomized operations.
module tb_alu_serial;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   ctrl = 3'b000;
  logic         in_ready, out_valid, flag_n, flag_z, flag_c, flag_v;
  logic [W-1:0] result;

  alu_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_flg = '0;
  logic [W+3:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  // returns {n, z, c, v, result}
  function automatic logic [W+3:0] model(logic [W-1:0] ta, logic [W-1:0] tb, logic tc, logic [2:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'b000: r = tb;
      3'b010: begin
        s = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        r = s[W-1:0];
        c = s[W];
        v = (ta[W-1] == tb[W-1]) && (r[W-1] != ta[W-1]);
      end
      3'b011: begin
        r = ta - tb;
        c = (ta >= tb);
        v = (ta[W-1] != tb[W-1]) && (r[W-1] != ta[W-1]);
      end
      3'b100: r = ta & tb;
      3'b101: r = ta | tb;
      3'b110: r = ta ^ tb;
`ifdef ALU_SLT_EN
      3'b111: r = ($signed(ta) < $signed(tb)) ? 1 : 0;
`endif
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("spurious_out_valid");
        end else begin
          if (!prev_ov) chk("latency", cyc - acc_cyc, NS);
          chk("result", {16'b0, result}, {16'b0, exp_q[0][W-1:0]});
          chk("flags_nzcv", {28'b0, flag_n, flag_z, flag_c, flag_v}, {28'b0, exp_q[0][W+3:W]});
          last_res = result;
          last_flg = {flag_n, flag_z, flag_c, flag_v};
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [2:0] op, input int hold, input bit poke);
    int t;
    step();
    a = ta; b = tb; cin = tc; ctrl = op; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    if (t >= 50) fail_now("timeout_accept");
    exp_q.push_back(model(ta, tb, tc, op));
    step();
    acc_cyc = cyc;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); ctrl = 3'($urandom);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    if (t >= 50) fail_now("timeout_out_valid");
    if (poke) begin
      in_valid = 1'b1;
      a = 16'h1111; b = 16'h2222; ctrl = 3'b010;
    end
    repeat (hold) step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin step(); t++; end
    if (t >= 50) fail_now("timeout_consume");
    out_ready = 1'b0;
  endtask

  task automatic do_lit(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [2:0] op, input logic [W-1:0] rres, input logic [3:0] rflg);
    do_op(ta, tb, tc, op, 0, 1'b0);
    chk({name, "_result"}, {16'b0, last_res}, {16'b0, rres});
    chk({name, "_nzcv"}, {28'b0, last_flg}, {28'b0, rflg});
  endtask

  logic [2:0] ops [8];

  initial begin
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    rst_n = 1'b1;

    do_lit("add_00ff", 16'h00FF, 16'h0001, 1'b0, 3'b010, 16'h0100, 4'b0000);
    do_lit("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 3'b010, 16'h0000, 4'b0110);
    do_lit("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 3'b010, 16'h8000, 4'b1001);
    do_lit("add_cin",  16'h0010, 16'h0020, 1'b1, 3'b010, 16'h0031, 4'b0000);
    do_lit("sub_3_5",  16'h0003, 16'h0005, 1'b1, 3'b011, 16'hFFFE, 4'b1000);
    do_lit("sub_eq",   16'h1234, 16'h1234, 1'b0, 3'b011, 16'h0000, 4'b0110);
    do_lit("and",      16'hA5A5, 16'h0FF0, 1'b0, 3'b100, 16'h05A0, 4'b0000);
    do_lit("or",       16'hA5A5, 16'h0FF0, 1'b0, 3'b101, 16'hAFF5, 4'b1000);
    do_lit("xor",      16'hA5A5, 16'h0FF0, 1'b0, 3'b110, 16'hAA55, 4'b1000);
    do_lit("pass_b",   16'hA5A5, 16'h0FF0, 1'b1, 3'b000, 16'h0FF0, 4'b0000);
    do_lit("rsv_001",  16'hA5A5, 16'h0FF0, 1'b1, 3'b001, 16'h0000, 4'b0100);
`ifdef ALU_SLT_EN
    do_lit("slt_neg",  16'hFFFF, 16'h0001, 1'b0, 3'b111, 16'h0001, 4'b0000);
    do_lit("slt_pos",  16'h0005, 16'h8000, 1'b0, 3'b111, 16'h0000, 4'b0100);
`else
    do_lit("rsv_111",  16'hFFFF, 16'h0001, 1'b0, 3'b111, 16'h0000, 4'b0100);
`endif

    // back-pressure: results held 5 cycles while a new request is offered
    do_op(16'h4321, 16'h1234, 1'b0, 3'b010, 5, 1'b1);
    chk("hold_result", {16'b0, last_res}, 32'h5555);
    chk("after_consume_in_ready", {31'b0, in_ready}, 32'd1);
    chk("after_consume_out_valid", {31'b0, out_valid}, 32'd0);
    step(); step();
    chk("poke_not_accepted", {31'b0, out_valid}, 32'd0);

    // reset two slices into a run
    step();
    a = 16'hFFFF; b = 16'h0FFF; cin = 1'b0; ctrl = 3'b100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_result", {16'b0, result}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    do_lit("post_rst_sub", 16'h0100, 16'h0001, 1'b0, 3'b011, 16'h00FF, 4'b0010);

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) ra = 16'h7FFF;
      if (i % 10 == 5) rb = 16'h8000;
      do_op(ra, rb, 1'($urandom), ops[$urandom_range(0, 7)], $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, digit-serial successor to the 4-bit combinational ALU slice.
- Processes a WIDTH-bit operation SLICE bits per cycle through one shared SLICE-bit ALU slice, passing the carry between cycles in a register.
- Used in area-constrained datapaths (multi-cycle CPU, coprocessor) where one result per several cycles is acceptable.
- Valid/ready handshake on both input and output; produces NZCV flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE, NSLICE >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/ctrl valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for ADD.
- ctrl  input  3  opcode: PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110; 001 and 111 reserved.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  ALU result.
- flag_n  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_c  output  1  carry out of the MSB (ADD/SUB), else 0.
- flag_v  output  1  signed overflow (ADD/SUB), else 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, slice counter 0, carry register 0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1 at a clock edge: latch a, b and ctrl; go to RUN; counter=0.
- Initial carry register value on acceptance:
  - ADD: cin.
  - SUB: 1; b is inverted per slice and cin is ignored.
  - All other ops: 0.
- RUN: in_ready=0, out_valid=0.
  - Each cycle the slice takes bits [cnt*SLICE +: SLICE] of the latched operands with the carry register.
  - At the edge: write the result slice, update the carry register, increment cnt.
  - When cnt == NSLICE-1 at the edge, go to DONE and finalise the flags.
- Flags (finalised entering DONE):
  - C = final carry out.
  - V = carry into MSB xor carry out of MSB.
  - C and V are forced to 0 for non-arithmetic ops.
  - Z and N are computed from the complete result.
- DONE: out_valid=1; result and flags held stable.
  - out_ready=1 at an edge: go to IDLE.
  - out_ready=0: hold indefinitely.
- Latency: out_valid rises exactly NSLICE cycles after the accepting edge. Minimum spacing between accepts is NSLICE+2 cycles; there is no overlap of operations.
- Arithmetic is modulo 2^WIDTH. SUB gives A-B. For unsigned A<B, C=0 (borrow convention: C = not-borrow).
- Reserved opcodes (001, 111 without the option): result=0, Z=1, N=C=V=0, same latency.
- in_valid is ignored outside IDLE. Operands are latched, so input changes after acceptance have no effect.
- Reset asserted mid-operation aborts it immediately; no out_valid is produced for the aborted operation.
- NSLICE=1 is a legal degenerate case: one RUN cycle.

Optional Feature:
- Macro ALU_SLT_EN.
- Defined: opcode 111 = signed set-less-than.
  - Performs SUB internally through the slices.
  - On entering DONE: result = {WIDTH-1 zeros, N_sub xor V_sub}.
  - Flags: Z and N from the final result; C=V=0.
- Undefined: 111 is reserved, as above.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [2:0] alu_ctrl_e with the opcode values above.
  - typedef enum state_e {IDLE, RUN, DONE}.
- One sub-module, alu_slice, is natural:
  - Parametrised SLICE-bit combinational ALU.
  - Ports: a, b, cin, ctrl, out, cout, c_msb_in (carry into the top bit, used for V).
  - Contains the ripple carry.
- The top level holds the FSM, counter, operand registers, carry register and result assembly.

Test Plan:
- WIDTH=16, SLICE=4; ADD a=16'h00FF, b=16'h0001, cin=0 -> after 4 cycles result=16'h0100, N=0, Z=0, C=0, V=0.
- ADD a=16'hFFFF, b=16'h0001 -> result=0, Z=1, C=1, V=0; ADD a=16'h7FFF, b=16'h0001 -> result=16'h8000, N=1, V=1, C=0.
- SUB a=16'h0003, b=16'h0005 -> result=16'hFFFE, N=1, C=0; SUB a=b=16'h1234 -> result=0, Z=1, C=1.
- AND/OR/XOR/PASS_B with a=16'hA5A5, b=16'h0FF0 -> result 16'h05A0 / 16'hAFF5 / 16'hAA55 / 16'h0FF0, C=V=0.
- Hold out_ready=0 for 5 cycles in DONE: result stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Assert rst_n=0 during RUN (cnt=2): out_valid=0 and in_ready=1 immediately. A new op after release completes correctly. With ALU_SLT_EN: a=16'hFFFF, b=16'h0001 -> result=1.
